ram_vga_arbiter: RTL and testbench

Per-cycle arbiter sharing the single-port 256×32 data RAM between the processor core's load/store port and the VGA pixel-fetch unit. It sits between `top` (CPU + memories) and `main_vga`. The VGA side is favoured during active video and the CPU during blanking. A starvation counter bounds CPU stall time, and a registered owner tag routes read data back one cycle after each grant.

---
 rtl/ram_vga_arbiter.sv | 115 +++++++++++
 tb/tb_ram_vga_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_vga_arbiter.sv
// Per-cycle arbiter for the shared 256x32 data RAM: CPU load/store port vs VGA pixel fetch.
// VGA wins conflicts in active video, CPU in blanking; a stall counter bounds CPU starvation.
module ram_vga_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_active,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflicts
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    owner_t     owner;
    owner_t     owner_nxt;
    logic       both_req;

    assign both_req = cpu_req & vga_req;

    // Grant decision; everything is held off while reset is asserted so a
    // write presented in the reset cycle never reaches the RAM.
    always_comb begin
        cpu_gnt = 1'b0;
        vga_gnt = 1'b0;
        if (!rst) begin
            if (both_req) begin
                if (wait_cnt == WAIT_MAX || !vga_active)
                    cpu_gnt = 1'b1;
                else
                    vga_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                vga_gnt = vga_req;
            end
        end
    end

    always_comb begin
        ram_en    = cpu_gnt | vga_gnt;
        ram_we    = cpu_gnt & cpu_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (vga_gnt) begin
            ram_addr  = vga_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 4'd0;
        else if (cpu_req && !cpu_gnt) begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 4'd1;
        end else
            wait_cnt <= 4'd0;
    end

    // Owner tag steers the RAM's 1-cycle-late read data to the right requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (cpu_gnt && !cpu_we)
            owner_nxt = OWN_CPU;
        else if (vga_gnt)
            owner_nxt = OWN_VGA;
    end

    assign cpu_rvalid = (owner == OWN_CPU);
    assign vga_rvalid = (owner == OWN_VGA);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign vga_rdata  = vga_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflicts <= 16'd0;
        else if (both_req && conflicts != 16'hFFFF)
            conflicts <= conflicts + 16'd1;
    end

endmodule

// File: tb/tb_ram_vga_arbiter.sv
// Randomized + directed bench for ram_vga_arbiter with a behavioural RAM and
// an arbitration model built from the grant/stall/read-return rules.
module tb_ram_vga_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_active = 1'b0;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [15:0]       conflicts;

    ram_vga_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_active(vga_active),
        .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM, read-first, 1-cycle latency.
    logic [DATA_W-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] mdl_mem [256] = '{default: '0};
    int                stall = 0;      // consecutive ungranted CPU request cycles
    int                conf = 0;
    bit                pend_cpu = 0, pend_vga = 0;
    logic [DATA_W-1:0] pend_data = '0;
    bit                last_cg = 0, last_vg = 0;
    logic              seen_cg, seen_vg;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs driven; checks, then advances one cycle.
    task automatic step();
        bit exp_cg, exp_vg;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        #1;
        if (rst) begin
            stall = 0; conf = 0; pend_cpu = 0; pend_vga = 0;
        end
        exp_cg = 0; exp_vg = 0;
        if (!rst) begin
            if (cpu_req && vga_req) begin
                if (stall >= MAX_WAIT || !vga_active) exp_cg = 1;
                else exp_vg = 1;
            end else begin
                exp_cg = cpu_req;
                exp_vg = vga_req;
            end
        end
        a = exp_cg ? cpu_addr : (exp_vg ? vga_addr : '0);
        d = exp_cg ? cpu_wdata : '0;
        seen_cg = cpu_gnt;
        seen_vg = vga_gnt;
        chk("cpu_gnt", cpu_gnt, exp_cg);
        chk("vga_gnt", vga_gnt, exp_vg);
        chk("ram_en", ram_en, exp_cg | exp_vg);
        chk("ram_we", ram_we, exp_cg & cpu_we);
        chk("ram_addr", ram_addr, a);
        chk("ram_wdata", ram_wdata, d);
        chk("cpu_rvalid", cpu_rvalid, pend_cpu);
        chk("vga_rvalid", vga_rvalid, pend_vga);
        chk("cpu_rdata", cpu_rdata, pend_cpu ? pend_data : '0);
        chk("vga_rdata", vga_rdata, pend_vga ? pend_data : '0);
        chk("conflicts", conflicts, conf);
        if (!rst) begin
            if (cpu_req && vga_req && conf < 65535) conf++;
            if (cpu_req && !exp_cg) stall++;
            else stall = 0;
            pend_cpu  = exp_cg && !cpu_we;
            pend_vga  = exp_vg;
            pend_data = mdl_mem[a];
            if (exp_cg && cpu_we) mdl_mem[cpu_addr] = cpu_wdata;
        end
        last_cg = exp_cg;
        last_vg = exp_vg;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        if (cpu_req && !last_cg) begin
            if ($urandom_range(0, 7) == 0) cpu_req = 1'b0;
        end else begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = ADDR_W'($urandom_range(0, 15));
            cpu_wdata = $urandom;
        end
        if (vga_req && !last_vg) begin
            if ($urandom_range(0, 7) == 0) vga_req = 1'b0;
        end else begin
            vga_req  = ($urandom_range(0, 3) != 0);
            vga_addr = ADDR_W'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 3) == 0) vga_active = ~vga_active;
        rst = ($urandom_range(0, 199) == 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        step();                        // reset held: all outputs quiet
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("idle_conflicts", conflicts, 16'd0);

        // CPU write then read back
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
        step();
        chk("wr_gnt", seen_cg, 1'b1);
        cpu_we = 0;
        step();
        cpu_req = 0;
        chk("wr_rd_rvalid", cpu_rvalid, 1'b1);
        chk("wr_rd_data", cpu_rdata, 32'hDEADBEEF);
        step();

        // Starvation bound in active video
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03; vga_req = 1; vga_addr = 8'h04; vga_active = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("starve_cpu_gnt", seen_cg, i == 4);
            chk("starve_vga_gnt", seen_vg, i != 4);
        end
        chk("starve_conflicts", conflicts, 16'd5);
        step();
        chk("starve_vga_again", seen_vg, 1'b1);

        // Blanking: CPU always wins
        vga_active = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("blank_cpu_gnt", seen_cg, 1'b1);
            chk("blank_vga_gnt", seen_vg, 1'b0);
        end

        // Reset right after a VGA read grant; a write in the reset cycle is dropped
        cpu_req = 0; vga_req = 1; vga_addr = 8'h20; vga_active = 1;
        step();
        chk("rst_vga_granted", seen_vg, 1'b1);
        rst = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 32'h12345678;
        step();
        chk("rst_vga_rvalid", vga_rvalid, 1'b0);
        chk("rst_no_write", seen_cg, 1'b0);
        rst = 0; cpu_req = 0; vga_req = 0;
        step();
        chk("rst_vga_rvalid2", vga_rvalid, 1'b0);
        chk("rst_conflicts", conflicts, 16'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        step();
        cpu_req = 0;
        chk("rst_write_dropped", cpu_rdata, 32'hDEADBEEF);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        rst = 0;

        // Conflict counter saturation
        pulse_reset();
        cpu_req = 1; vga_req = 1; cpu_we = 0;
        for (int i = 0; i < 70000; i++) begin
            vga_active = $urandom_range(0, 1) == 1;
            step();
        end
        chk("conflicts_sat", conflicts, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
